// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver and scan-code set 2 decoder driving held levels for eight game keys.
//   CLK100MHZ, RST        system clock, synchronous active-high reset
//   PS2_CLK, PS2_DATA     raw asynchronous keyboard lines (idle high)
//   ESC, R, S, P          held levels for make codes 76, 2D, 1B, 4D
//   UP, DOWN, LEFT, RIGHT held levels for extended make codes E0 75/72/6B/74
//   SCAN_CODE             last accepted byte, CODE_VALID pulses when it updates
//   FRAME_ERR             one-cycle pulse on a rejected frame
//   Define PS2_PARITY_CHECK_EN to reject frames whose parity is not odd.
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       CLK100MHZ,
   input  logic       RST,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic       ESC,
   output logic       R,
   output logic       S,
   output logic       P,
   output logic       UP,
   output logic       DOWN,
   output logic       LEFT,
   output logic       RIGHT,
   output logic [7:0] SCAN_CODE,
   output logic       CODE_VALID,
   output logic       FRAME_ERR
);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   logic [1:0]            clk_s_q, dat_s_q;
   logic [FILTER_LEN-1:0] hist_q;
   logic                  filt_q, filt_d, fall, dat, accept;
   state_t                state_q;
   logic [2:0]            cnt_q;
   logic [7:0]            shift_q, scan_q, key_q, hit_d;
   logic                  par_q, ext_q, brk_q, valid_q, err_q;
   logic [TW-1:0]         tmo_q;
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         clk_s_q <= '1;
         dat_s_q <= '1;
         hist_q  <= '1;
         filt_q  <= 1'b1;
      end else begin
         clk_s_q <= {clk_s_q[0], PS2_CLK};
         dat_s_q <= {dat_s_q[0], PS2_DATA};
         hist_q  <= {hist_q[FILTER_LEN-2:0], clk_s_q[1]};
         filt_q  <= filt_d;
      end
   end
   // The filtered clock flips only when the whole history window agrees.
   assign filt_d = &hist_q ? 1'b1 : ~|hist_q ? 1'b0 : filt_q;
   assign fall   = filt_q & ~filt_d;
   assign dat    = dat_s_q[1];
   // In STOP the sampled bit is the stop bit itself.
   assign accept = dat & (~PAR_EN | ^{shift_q, par_q});
   always_comb begin
      hit_d = '0;
      case ({ext_q, shift_q})
         9'h076:  hit_d[0] = 1'b1;
         9'h02D:  hit_d[1] = 1'b1;
         9'h01B:  hit_d[2] = 1'b1;
         9'h04D:  hit_d[3] = 1'b1;
         9'h175:  hit_d[4] = 1'b1;
         9'h172:  hit_d[5] = 1'b1;
         9'h16B:  hit_d[6] = 1'b1;
         9'h174:  hit_d[7] = 1'b1;
         default: hit_d = '0;
      endcase
   end
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
         scan_q  <= '0;
         key_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (fall) begin
            tmo_q <= '0;
            case (state_q)
               IDLE: if (!dat) begin
                  state_q <= DATA;
                  cnt_q   <= '0;
               end
               DATA: begin
                  shift_q <= {dat, shift_q[7:1]};
                  cnt_q   <= cnt_q + 3'd1;
                  state_q <= (cnt_q == 3'd7) ? PARITY : DATA;
               end
               PARITY: begin
                  par_q   <= dat;
                  state_q <= STOP;
               end
               default: begin
                  state_q <= IDLE;
                  if (accept) begin
                     scan_q  <= shift_q;
                     valid_q <= 1'b1;
                     if (shift_q == 8'hE0) ext_q <= 1'b1;
                     else if (shift_q == 8'hF0) brk_q <= 1'b1;
                     else begin
                        key_q <= brk_q ? (key_q & ~hit_d) : (key_q | hit_d);
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                     end
                  end else begin
                     err_q <= 1'b1;
                     ext_q <= 1'b0;
                     brk_q <= 1'b0;
                  end
               end
            endcase
         end else if (state_q != IDLE) begin
            // A stalled frame is silently dropped; ext/brk and keys are kept.
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_q <= IDLE;
               tmo_q   <= '0;
            end else tmo_q <= tmo_q + 1'b1;
         end
      end
   end
   assign {RIGHT, LEFT, DOWN, UP, P, S, R, ESC} = key_q;
   assign SCAN_CODE  = scan_q;
   assign CODE_VALID = valid_q;
   assign FRAME_ERR  = err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: randomized PS/2 frames checked against a byte-level key model.
module tb_ps2_key_decoder;
   localparam int H = 20;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   logic clk = 0, rst = 1, ps2c = 1, ps2d = 1;
   logic esc, r, s, p, up, down, left, right, code_valid, frame_err;
   logic [7:0] scan_code, dut_keys;
   int tests = 0, fails = 0;
   logic [7:0] m_keys = '0, m_scan = '0;
   bit m_ext = 0, m_brk = 0, check_en = 0;
   int m_valid = 0, m_err = 0, d_valid = 0, d_err = 0;
   logic prev_valid = 0, prev_err = 0;
   logic [7:0] pool [12] = '{8'h76, 8'h2D, 8'h1B, 8'h4D, 8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0};

   ps2_key_decoder dut (
      .CLK100MHZ(clk), .RST(rst), .PS2_CLK(ps2c), .PS2_DATA(ps2d),
      .ESC(esc), .R(r), .S(s), .P(p), .UP(up), .DOWN(down), .LEFT(left), .RIGHT(right),
      .SCAN_CODE(scan_code), .CODE_VALID(code_valid), .FRAME_ERR(frame_err)
   );

   always #5 clk = ~clk;
   assign dut_keys = {right, left, down, up, p, s, r, esc};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         d_valid = 0;
         d_err = 0;
         prev_valid = 0;
         prev_err = 0;
      end else begin
         if (code_valid) begin
            d_valid++;
            chk("valid_one_cycle", prev_valid, 0);
         end
         if (frame_err) begin
            d_err++;
            chk("err_one_cycle", prev_err, 0);
         end
         if (check_en) begin
            chk("keys", dut_keys, m_keys);
            chk("scan", scan_code, m_scan);
         end
         prev_valid = code_valid;
         prev_err = frame_err;
      end
   end

   function automatic int key_idx(input bit e, input logic [7:0] b);
      logic [7:0] plain [4] = '{8'h76, 8'h2D, 8'h1B, 8'h4D};
      logic [7:0] extc  [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
      for (int i = 0; i < 4; i++) begin
         if (!e && b == plain[i]) return i;
         if (e && b == extc[i]) return i + 4;
      end
      return -1;
   endfunction

   task automatic model_byte(input logic [7:0] b, input bit ok);
      int k;
      if (!ok) begin
         m_err++;
         m_ext = 0;
         m_brk = 0;
      end else begin
         m_valid++;
         m_scan = b;
         if (b == 8'hE0) m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else begin
            k = key_idx(m_ext, b);
            if (k >= 0) m_keys[k] = !m_brk;
            m_ext = 0;
            m_brk = 0;
         end
      end
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2d = bits[i];
         repeat (H) @(posedge clk);
         ps2c = 0;
         repeat (H) @(posedge clk);
         ps2c = 1;
      end
      ps2d = 1;
   endtask

   task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      check_en = 0;
      send_bits({~bad_stop, (~^b) ^ bad_par, b, 1'b0}, 11);
      repeat (H) @(posedge clk);
      model_byte(b, !bad_stop && (!PAR_EN || !bad_par));
      chk("valid_count", d_valid, m_valid);
      chk("err_count", d_err, m_err);
      check_en = 1;
   endtask

   task automatic do_reset();
      check_en = 0;
      @(posedge clk);
      rst = 1;
      repeat (3) @(posedge clk);
      rst = 0;
      m_keys = '0;
      m_scan = '0;
      m_ext = 0;
      m_brk = 0;
      m_valid = 0;
      m_err = 0;
      @(negedge clk);
      chk("rst_keys", dut_keys, 0);
      chk("rst_scan", scan_code, 0);
      chk("rst_valid", code_valid, 0);
      chk("rst_err", frame_err, 0);
      check_en = 1;
   endtask

   initial begin
      int sv, se, kb;
      do_reset();
      frame(8'h2D, 0, 0);
      chk("R_make", r, 1);
      chk("R_scan", scan_code, 8'h2D);
      chk("R_one_pulse", d_valid, 1);
      frame(8'hF0, 0, 0);
      frame(8'h2D, 0, 0);
      chk("R_break", r, 0);
      frame(8'hE0, 0, 0);
      chk("UP_after_E0", up, 0);
      frame(8'h75, 0, 0);
      chk("UP_make", up, 1);
      frame(8'hE0, 0, 0);
      frame(8'hF0, 0, 0);
      chk("UP_held_midbreak", up, 1);
      frame(8'h75, 0, 0);
      chk("UP_break", up, 0);
      sv = d_valid;
      frame(8'h75, 0, 0);
      chk("lone75_up", up, 0);
      chk("lone75_pulse", d_valid, sv + 1);
      se = d_err;
      frame(8'h1B, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
      chk("badpar_S", s, 0);
      chk("badpar_err", d_err, se + 1);
`else
      chk("badpar_S", s, 1);
      chk("badpar_err", d_err, se);
`endif
      check_en = 0;
      send_bits({2'b11, 8'hA5, 1'b0}, 5);
      check_en = 1;
      repeat (20050) @(posedge clk);
      se = d_err;
      frame(8'h76, 0, 0);
      chk("timeout_ESC", esc, 1);
      chk("timeout_no_err", d_err, se);
      check_en = 0;
      send_bits({2'b11, 8'h4D, 1'b0}, 6);
      do_reset();
      frame(8'h4D, 0, 0);
      chk("post_rst_P", p, 1);
      sv = d_valid;
      kb = dut_keys;
      ps2c = 0;
      repeat (3) @(posedge clk);
      ps2c = 1;
      repeat (40) @(posedge clk);
      chk("glitch_no_pulse", d_valid, sv);
      chk("glitch_keys", dut_keys, kb);
      frame(8'h2D, 0, 0);
      chk("glitch_then_R", r, 1);
      for (int i = 0; i < 40; i++) begin
         logic [7:0] b;
         b = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 11)];
         frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      end
      check_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
